// File: rtl/program_loader.sv
// Byte-stream boot loader: parses SYNC/addr/count/data frames and writes 16-bit words
// into instruction memory, holding the CPU in reset while a frame is in flight.
// Optional trailing 8-bit checksum byte: define LOADER_CHECKSUM_EN.
module program_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        pc_reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] instruction_in,
  output logic [15:0] load_address,
  output logic        load_instruction,
  output logic        cpu_pc_reset,
  output logic        done,
  output logic        error
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_DONE,
    S_ERROR
`ifdef LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   r_remaining;
  logic [BW-1:0]   r_cnt_hi;
  logic [BW-1:0]   r_data_hi;
  logic            r_byte_ready;
  logic [DW-1:0]   r_instruction_in;
  logic [AW-1:0]   r_load_address;
  logic            r_load_instruction;
  logic            r_cpu_pc_reset;
  logic            r_done;
  logic            r_error;

  logic            w_xfer;
  logic            w_is_sync;
  logic [AW-1:0]   w_count;

  assign w_xfer    = byte_valid & r_byte_ready;
  assign w_is_sync = (byte_in == SYNC_BYTE);
  assign w_count   = {r_cnt_hi, byte_in};

  assign byte_ready       = r_byte_ready;
  assign instruction_in   = r_instruction_in;
  assign load_address     = r_load_address;
  assign load_instruction = r_load_instruction;
  assign cpu_pc_reset     = r_cpu_pc_reset;
  assign done             = r_done;
  assign error            = r_error;

`ifdef LOADER_CHECKSUM_EN
  logic [BW-1:0] r_csum;

  // Running 8-bit sum of every accepted byte between SYNC and CHK
  always_ff @(posedge clk) begin
    if (pc_reset) begin
      r_csum <= '0;
    end else if (w_xfer) begin
      if (r_state == S_IDLE || r_state == S_ERROR) begin
        r_csum <= '0;
      end else if (r_state != S_CHECK) begin
        r_csum <= r_csum + byte_in;
      end
    end
  end
`endif

  // Frame parser FSM with registered outputs
  always_ff @(posedge clk) begin
    if (pc_reset) begin
      r_state            <= S_IDLE;
      r_addr             <= '0;
      r_remaining        <= '0;
      r_cnt_hi           <= '0;
      r_data_hi          <= '0;
      r_byte_ready       <= 1'b1;
      r_instruction_in   <= '0;
      r_load_address     <= '0;
      r_load_instruction <= 1'b0;
      r_cpu_pc_reset     <= 1'b0;
      r_done             <= 1'b0;
      r_error            <= 1'b0;
    end else begin
      r_load_instruction <= 1'b0;
      r_done             <= 1'b0;
      r_byte_ready       <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_xfer && w_is_sync) begin
            r_state        <= S_ADDR_HI;
            r_cpu_pc_reset <= 1'b1;
          end
        end
        S_ADDR_HI: begin
          if (w_xfer) begin
            r_addr[15:8] <= byte_in;
            r_state      <= S_ADDR_LO;
          end
        end
        S_ADDR_LO: begin
          if (w_xfer) begin
            r_addr[7:0] <= byte_in;
            r_state     <= S_CNT_HI;
          end
        end
        S_CNT_HI: begin
          if (w_xfer) begin
            r_cnt_hi <= byte_in;
            r_state  <= S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (w_xfer) begin
            if (w_count > AW'(MAX_WORDS)) begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end else if (w_count == '0) begin
`ifdef LOADER_CHECKSUM_EN
              r_state      <= S_CHECK;
`else
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_byte_ready <= 1'b0;
`endif
            end else begin
              r_remaining <= w_count;
              r_state     <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (w_xfer) begin
            r_data_hi <= byte_in;
            r_state   <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (w_xfer) begin
            r_instruction_in   <= {r_data_hi, byte_in};
            r_load_address     <= r_addr;
            r_load_instruction <= 1'b1;
            r_byte_ready       <= 1'b0;
            r_state            <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_addr      <= r_addr + AW'(1);
          r_remaining <= r_remaining - AW'(1);
          if (r_remaining == AW'(1)) begin
`ifdef LOADER_CHECKSUM_EN
            r_state      <= S_CHECK;
`else
            r_state      <= S_DONE;
            r_done       <= 1'b1;
            r_byte_ready <= 1'b0;
`endif
          end else begin
            r_state <= S_DATA_HI;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_xfer) begin
            if (byte_in == r_csum) begin
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_byte_ready <= 1'b0;
            end else begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end
          end
        end
`endif
        S_DONE: begin
          r_cpu_pc_reset <= 1'b0;
          r_state        <= S_IDLE;
        end
        S_ERROR: begin
          if (w_xfer && w_is_sync) begin
            r_error <= 1'b0;
            r_state <= S_ADDR_HI;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table of frames plus hand-written
// reset and boundary sequences. Follows LOADER_CHECKSUM_EN if defined.
module tb_program_loader;

  logic        clk;
  logic        pc_reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] instruction_in;
  logic [15:0] load_address;
  logic        load_instruction;
  logic        cpu_pc_reset;
  logic        done;
  logic        error;

  program_loader dut (
    .clk              (clk),
    .pc_reset         (pc_reset),
    .byte_in          (byte_in),
    .byte_valid       (byte_valid),
    .byte_ready       (byte_ready),
    .instruction_in   (instruction_in),
    .load_address     (load_address),
    .load_instruction (load_instruction),
    .cpu_pc_reset     (cpu_pc_reset),
    .done             (done),
    .error            (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] bytes;   // frame bytes, last byte in the low 8 bits
    int           len;
    int           sof;     // index of the SYNC byte that opens the frame
    bit           bad_chk;
    bit           gaps;
    int           n_wr;
    logic [31:0]  w0;      // {address, data}
    logic [31:0]  w1;
    int           e_done;
    bit           e_err;
  } vec_t;

  vec_t vecs [10];
  int   nvec;
  int   pass_cnt;
  int   total_cnt;

  // Monitor: logs strobes, done pulses and byte_ready protocol violations
  logic [31:0] wr_log [64];
  int          wr_total;
  int          done_total;
  int          viol_total;
  logic        pcr_at_done;

  initial begin
    wr_total    = 0;
    done_total  = 0;
    viol_total  = 0;
    pcr_at_done = 1'b0;
  end

  always @(negedge clk) begin
    if (!pc_reset) begin
      if (load_instruction) begin
        if (wr_total < 64) wr_log[wr_total] <= {load_address, instruction_in};
        wr_total <= wr_total + 1;
      end
      if (done) begin
        done_total  <= done_total + 1;
        pcr_at_done <= cpu_pc_reset;
      end
      if ((load_instruction && byte_ready) || (!byte_ready && !load_instruction && !done))
        viol_total <= viol_total + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add_vec(input logic [127:0] bytes, input int len, input int sof,
                         input bit bad, input bit gaps, input int nwr,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input int edone, input bit eerr);
    vecs[nvec].bytes   = bytes;
    vecs[nvec].len     = len;
    vecs[nvec].sof     = sof;
    vecs[nvec].bad_chk = bad;
    vecs[nvec].gaps    = gaps;
    vecs[nvec].n_wr    = nwr;
    vecs[nvec].w0      = w0;
    vecs[nvec].w1      = w1;
    vecs[nvec].e_done  = edone;
    vecs[nvec].e_err   = eerr;
    nvec++;
  endtask

  // Entry and exit at posedge+1; holds byte_valid until the transfer edge
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    int guard;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    byte_in    = b;
    byte_valid = 1'b1;
    ok         = 1'b0;
    guard      = 0;
    while (!ok && guard < 20) begin
      @(negedge clk);
      ok = byte_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    byte_valid = 1'b0;
    if (!ok) begin
      total_cnt++;
      $display("FAIL xfer_timeout: byte 0x%02h not accepted within 20 cycles", b);
    end
  endtask

  task automatic send_frame(input vec_t v);
    logic [7:0] b;
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < v.len; i++) begin
      b = v.bytes[8*(v.len-1-i) +: 8];
      if (i > v.sof) sum = sum + b;
      send_byte(b, v.gaps);
    end
`ifdef LOADER_CHECKSUM_EN
    if (!v.e_err || v.bad_chk) send_byte(v.bad_chk ? sum + 8'h01 : sum, v.gaps);
`endif
  endtask

  initial begin
    int wr_base;
    int done_base;
    int viol_base;
    logic [31:0] last_w;

    pass_cnt   = 0;
    total_cnt  = 0;
    nvec       = 0;
    pc_reset   = 1'b1;
    byte_valid = 1'b0;
    byte_in    = 8'h00;

    //       bytes                                len sof bad gap nwr w0               w1               done err
    add_vec(128'hA5_00_10_00_02_12_34_AB_CD,      9,  0,  0,  0,  2,  32'h0010_1234,  32'h0011_ABCD,  1,   0);
    add_vec(128'hA5_00_10_00_02_12_34_AB_CD,      9,  0,  0,  1,  2,  32'h0010_1234,  32'h0011_ABCD,  1,   0);
    add_vec(128'hA5_FF_FF_00_02_00_01_00_02,      9,  0,  0,  0,  2,  32'hFFFF_0001,  32'h0000_0002,  1,   0);
    add_vec(128'hA5_00_00_00_00,                  5,  0,  0,  0,  0,  32'h0,          32'h0,          1,   0);
    add_vec(128'h12_A5_00_20_00_01_A5_5A,         8,  1,  0,  1,  1,  32'h0020_A55A,  32'h0,          1,   0);
`ifdef LOADER_CHECKSUM_EN
    add_vec(128'hA5_00_10_00_02_12_34_AB_CD,      9,  0,  1,  0,  2,  32'h0010_1234,  32'h0011_ABCD,  0,   1);
    add_vec(128'h33_A5_00_00_00_00,               6,  1,  0,  0,  0,  32'h0,          32'h0,          1,   0);
`endif
    add_vec(128'hA5_00_00_01_01,                  5,  0,  0,  0,  0,  32'h0,          32'h0,          0,   1);
    add_vec(128'h33_A5_00_00_00_00,               6,  1,  0,  1,  0,  32'h0,          32'h0,          1,   0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    pc_reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_byte_ready", {31'b0, byte_ready}, 32'd1);
    check("rst_outputs", {13'b0, load_instruction, cpu_pc_reset, done, error}, 32'd0);
    check("rst_addr_data", {load_address, instruction_in}, 32'd0);

    // Table-driven frames
    last_w = 32'h0;
    for (int k = 0; k < nvec; k++) begin
      wr_base   = wr_total;
      done_base = done_total;
      viol_base = viol_total;
      send_frame(vecs[k]);
      repeat (6) @(posedge clk);
      #1;
      check($sformatf("v%0d_nwr", k), 32'(wr_total - wr_base), 32'(vecs[k].n_wr));
      if (vecs[k].n_wr > 0) begin
        check($sformatf("v%0d_wr0", k), wr_log[wr_base], vecs[k].w0);
        last_w = vecs[k].w0;
      end
      if (vecs[k].n_wr > 1) begin
        check($sformatf("v%0d_wr1", k), wr_log[wr_base+1], vecs[k].w1);
        last_w = vecs[k].w1;
      end
      check($sformatf("v%0d_hold", k), {load_address, instruction_in}, last_w);
      check($sformatf("v%0d_done", k), 32'(done_total - done_base), 32'(vecs[k].e_done));
      check($sformatf("v%0d_error", k), {31'b0, error}, {31'b0, vecs[k].e_err});
      check($sformatf("v%0d_cpu_rst", k), {31'b0, cpu_pc_reset}, {31'b0, vecs[k].e_err});
      check($sformatf("v%0d_ready_proto", k), 32'(viol_total - viol_base), 32'd0);
      if (vecs[k].e_done > 0)
        check($sformatf("v%0d_cpu_rst_in_done", k), {31'b0, pcr_at_done}, 32'd1);
    end

    // cpu_pc_reset rises right after the SYNC transfer
    send_byte(8'hA5, 1'b0);
    check("sync_cpu_rst", {31'b0, cpu_pc_reset}, 32'd1);

    // Count of exactly MAX_WORDS is legal; then reset after the first DATA_HI
    wr_base   = wr_total;
    done_base = done_total;
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    check("cnt256_no_error", {31'b0, error}, 32'd0);
    send_byte(8'h12, 1'b0);
    check("cnt256_in_frame", {30'b0, cpu_pc_reset, byte_ready}, 32'd3);
    pc_reset = 1'b1;
    @(posedge clk);
    #1;
    pc_reset = 1'b0;
    check("midrst_ready", {31'b0, byte_ready}, 32'd1);
    check("midrst_outputs", {13'b0, load_instruction, cpu_pc_reset, done, error}, 32'd0);
    check("midrst_addr_data", {load_address, instruction_in}, 32'd0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h77, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_strobe", 32'(wr_total - wr_base), 32'd0);
    check("midrst_no_done", 32'(done_total - done_base), 32'd0);
    check("midrst_idle", {30'b0, cpu_pc_reset, error}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, %0d/%0d done", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
